// File: rtl/hdr_extract_if.sv
// Stream-side and result-side signals of the header extractor.
// The parser takes the slave view; the upstream/downstream logic takes the master view.
interface hdr_extract_if #(
   parameter int C_S_AXIS_DATA_WIDTH = 256
);
   logic [C_S_AXIS_DATA_WIDTH-1:0] i_tdata;
   logic                           i_tvalid;
   logic                           i_tlast;
   logic                           i_pkt_word1;
   logic                           i_pkt_word2;
   logic                           i_pkt_is_from_cpu;
   logic                           i_pktstate_valid;
   logic                           o_rd_pktstate;
   logic                           o_hdr_valid;
   logic                           i_hdr_rd;
   logic [47:0]                    o_dst_mac;
   logic [15:0]                    o_ethertype;
   logic [7:0]                     o_ttl;
   logic [31:0]                    o_ip_dst;
   logic                           o_ip_ok;
   logic                           o_from_cpu;
   logic                           o_nearly_full;
   logic [15:0]                    o_drop_count;

   modport master (
      output i_tdata, i_tvalid, i_tlast, i_pkt_word1, i_pkt_word2,
             i_pkt_is_from_cpu, i_pktstate_valid, i_hdr_rd,
      input  o_rd_pktstate, o_hdr_valid, o_dst_mac, o_ethertype, o_ttl,
             o_ip_dst, o_ip_ok, o_from_cpu, o_nearly_full, o_drop_count
   );

   modport slave (
      input  i_tdata, i_tvalid, i_tlast, i_pkt_word1, i_pkt_word2,
             i_pkt_is_from_cpu, i_pktstate_valid, i_hdr_rd,
      output o_rd_pktstate, o_hdr_valid, o_dst_mac, o_ethertype, o_ttl,
             o_ip_dst, o_ip_ok, o_from_cpu, o_nearly_full, o_drop_count
   );
endinterface

// File: rtl/hdr_extract.sv
// Extracts Ethernet/IPv4 header fields from the first two 32-byte beats of a
// packet, checks the IPv4 header checksum, and queues results in a small FIFO.
module hdr_extract #(
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int FIFO_DEPTH_BITS      = 2
) (
   input  logic           axi_aclk,
   input  logic           axi_resetn,
   hdr_extract_if.slave   s
);

   localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;
   localparam logic [FIFO_DEPTH_BITS:0] DEPTH_C  = DEPTH[FIFO_DEPTH_BITS:0];
   localparam logic [FIFO_DEPTH_BITS:0] NEARLY_C = DEPTH_C - 1'b1;

   if (C_S_AXIS_DATA_WIDTH != 256 || C_S_AXIS_TUSER_WIDTH < 1) begin : g_param_check
      $error("hdr_extract: only a 256-bit stream is supported");
   end

   typedef enum logic {
      IDLE    = 1'b0,
      HAVE_W1 = 1'b1
   } state_t;

   typedef struct packed {
      logic [47:0] dst_mac;
      logic [15:0] ethertype;
      logic [7:0]  ttl;
      logic [31:0] ip_dst;
      logic        ip_ok;
      logic        from_cpu;
   } entry_t;

   // Byte n of a beat; multi-byte fields are big-endian.
   function automatic logic [7:0] byte_at(input logic [255:0] d, input int n);
      return d[8*n +: 8];
   endfunction

   function automatic logic [15:0] word_at(input logic [255:0] d, input int n);
      return {byte_at(d, n), byte_at(d, n + 1)};
   endfunction

   // Nine header words at bytes 14..31; nine 16-bit terms never exceed 20 bits.
   function automatic logic [19:0] partial_sum(input logic [255:0] d);
      logic [19:0] acc;
      acc = '0;
      for (int i = 0; i < 9; i++) begin
         acc = acc + {4'b0, word_at(d, 14 + 2*i)};
      end
      return acc;
   endfunction

   // Two end-around-carry folds are enough to bring a 21-bit sum to 16 bits.
   function automatic logic [15:0] fold_sum(input logic [20:0] sum);
      logic [16:0] f1;
      logic [15:0] f2;
      f1 = {1'b0, sum[15:0]} + {12'b0, sum[20:16]};
      f2 = f1[15:0] + {15'b0, f1[16]};
      return f2;
   endfunction

   function automatic logic hdr_ok(input logic [15:0] ethertype, input logic [7:0] vihl,
                                   input logic [15:0] folded, input logic [7:0] ttl);
      return (ethertype == 16'h0800) && (vihl == 8'h45) &&
             (folded == 16'hFFFF) && (ttl != 8'h00);
   endfunction

   state_t      state_q, state_d;
   logic [47:0] dst_mac_q, dst_mac_d;
   logic [15:0] ethertype_q, ethertype_d;
   logic [7:0]  vihl_q, vihl_d;
   logic [7:0]  ttl_q, ttl_d;
   logic [15:0] dst_hi_q, dst_hi_d;
   logic [19:0] csum_q, csum_d;

   entry_t                     mem_q [DEPTH];
   entry_t                     mem_d [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [FIFO_DEPTH_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [FIFO_DEPTH_BITS:0]   count_q, count_d;
   logic [15:0]                drop_cnt_q, drop_cnt_d;

   logic        beat_w1, beat_w2;
   logic        commit;
   entry_t      commit_entry;
   logic [15:0] folded;
   logic        fifo_rd, fifo_wr, fifo_full, drop;
   entry_t      head;
   logic        unused_bits;

   assign beat_w1 = s.i_tvalid & s.i_pkt_word1;
   assign beat_w2 = s.i_tvalid & s.i_pkt_word2;
   assign folded  = fold_sum({1'b0, csum_q} + {5'b0, word_at(s.i_tdata, 0)});

   // Source MAC (bytes 6-11) is not needed by the fast path.
   assign unused_bits = ^s.i_tdata[95:48];

   always_comb begin
      state_d      = state_q;
      dst_mac_d    = dst_mac_q;
      ethertype_d  = ethertype_q;
      vihl_d       = vihl_q;
      ttl_d        = ttl_q;
      dst_hi_d     = dst_hi_q;
      csum_d       = csum_q;
      commit       = 1'b0;
      commit_entry = '0;

      unique case (state_q)
         IDLE: begin
            if (beat_w1) begin
               if (s.i_tlast) begin
                  // Runt: only word1 exists, so the IP header cannot be complete.
                  commit                 = 1'b1;
                  commit_entry.dst_mac   = {word_at(s.i_tdata, 0), word_at(s.i_tdata, 2),
                                            word_at(s.i_tdata, 4)};
                  commit_entry.ethertype = word_at(s.i_tdata, 12);
                  commit_entry.ttl       = byte_at(s.i_tdata, 22);
                  commit_entry.ip_dst    = {word_at(s.i_tdata, 30), 16'h0000};
                  commit_entry.ip_ok     = 1'b0;
               end else begin
                  state_d     = HAVE_W1;
                  dst_mac_d   = {word_at(s.i_tdata, 0), word_at(s.i_tdata, 2),
                                 word_at(s.i_tdata, 4)};
                  ethertype_d = word_at(s.i_tdata, 12);
                  vihl_d      = byte_at(s.i_tdata, 14);
                  ttl_d       = byte_at(s.i_tdata, 22);
                  dst_hi_d    = word_at(s.i_tdata, 30);
                  csum_d      = partial_sum(s.i_tdata);
               end
            end
         end
         HAVE_W1: begin
            if (beat_w2) begin
               state_d                = IDLE;
               commit                 = 1'b1;
               commit_entry.dst_mac   = dst_mac_q;
               commit_entry.ethertype = ethertype_q;
               commit_entry.ttl       = ttl_q;
               commit_entry.ip_dst    = {dst_hi_q, word_at(s.i_tdata, 0)};
               commit_entry.ip_ok     = hdr_ok(ethertype_q, vihl_q, folded, ttl_q);
            end
         end
         default: state_d = IDLE;
      endcase

      commit_entry.from_cpu = commit & s.i_pktstate_valid & s.i_pkt_is_from_cpu;
   end

   // A read in the same cycle frees the slot, so a commit on a full FIFO still lands.
   always_comb begin
      fifo_full = (count_q == DEPTH_C);
      fifo_rd   = s.i_hdr_rd & (count_q != '0);
      fifo_wr   = commit & (~fifo_full | fifo_rd);
      drop      = commit & fifo_full & ~fifo_rd;

      mem_d = mem_q;
      if (fifo_wr) begin
         mem_d[wr_ptr_q] = commit_entry;
      end

      wr_ptr_d = fifo_wr ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_d = fifo_rd ? rd_ptr_q + 1'b1 : rd_ptr_q;

      unique case ({fifo_wr, fifo_rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase

      drop_cnt_d = (drop && drop_cnt_q != 16'hFFFF) ? drop_cnt_q + 16'd1 : drop_cnt_q;
   end

   always_ff @(posedge axi_aclk or negedge axi_resetn) begin
      if (!axi_resetn) begin
         state_q    <= IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         drop_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         drop_cnt_q <= drop_cnt_d;
      end
   end

   // Capture registers and FIFO storage carry no reset; valid/count gate their use.
   always_ff @(posedge axi_aclk) begin
      dst_mac_q   <= dst_mac_d;
      ethertype_q <= ethertype_d;
      vihl_q      <= vihl_d;
      ttl_q       <= ttl_d;
      dst_hi_q    <= dst_hi_d;
      csum_q      <= csum_d;
      mem_q       <= mem_d;
   end

   assign head = mem_q[rd_ptr_q];

   assign s.o_hdr_valid   = (count_q != '0);
   assign s.o_nearly_full = (count_q >= NEARLY_C);
   assign s.o_drop_count  = drop_cnt_q;
   assign s.o_rd_pktstate = commit & s.i_pktstate_valid & axi_resetn;
   assign s.o_dst_mac     = s.o_hdr_valid ? head.dst_mac   : '0;
   assign s.o_ethertype   = s.o_hdr_valid ? head.ethertype : '0;
   assign s.o_ttl         = s.o_hdr_valid ? head.ttl       : '0;
   assign s.o_ip_dst      = s.o_hdr_valid ? head.ip_dst    : '0;
   assign s.o_ip_ok       = s.o_hdr_valid & head.ip_ok;
   assign s.o_from_cpu    = s.o_hdr_valid & head.from_cpu;

endmodule

// File: tb/tb_hdr_extract.sv
// Randomized bench for hdr_extract against a byte-level packet model with a queue FIFO.
module tb_hdr_extract;

   localparam int DEPTH = 4;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   hdr_extract_if #(.C_S_AXIS_DATA_WIDTH(256)) bus ();

   hdr_extract #(
      .C_S_AXIS_DATA_WIDTH (256),
      .C_S_AXIS_TUSER_WIDTH(128),
      .FIFO_DEPTH_BITS     (2)
   ) dut (
      .axi_aclk  (clk),
      .axi_resetn(rst_n),
      .s         (bus)
   );

   typedef struct {
      logic [47:0] mac;
      logic [15:0] et;
      logic [7:0]  ttl;
      logic [31:0] dst;
      logic        ok;
      logic        cpu;
   } ent_t;

   ent_t        exp_q[$];
   int unsigned exp_drop = 0;
   int          n_chk    = 0;
   int          n_fail   = 0;
   logic [7:0]  pkt [0:95];

   task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, want %0h", tag, act, exp);
      end
   endtask

   task automatic idle_inputs();
      bus.i_tdata           = '0;
      bus.i_tvalid          = 1'b0;
      bus.i_tlast           = 1'b0;
      bus.i_pkt_word1       = 1'b0;
      bus.i_pkt_word2       = 1'b0;
      bus.i_pkt_is_from_cpu = 1'b0;
      bus.i_pktstate_valid  = 1'b0;
      bus.i_hdr_rd          = 1'b0;
   endtask

   function automatic int unsigned hdr_sum();
      int unsigned sum = 0;
      for (int i = 14; i < 34; i += 2) sum += {16'h0, pkt[i], pkt[i+1]};
      return sum;
   endfunction

   // Random packet with chosen fields; checksum made valid, or broken in one bit.
   task automatic build(input logic [47:0] mac, input logic [15:0] et, input logic [7:0] vihl,
                        input logic [7:0] ttl, input logic [31:0] dst, input bit good);
      int unsigned sum;
      logic [15:0] c;
      for (int i = 0; i < 96; i++) pkt[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 6; i++) pkt[i] = mac[47-8*i -: 8];
      pkt[12] = et[15:8];
      pkt[13] = et[7:0];
      pkt[14] = vihl;
      pkt[22] = ttl;
      for (int i = 0; i < 4; i++) pkt[30+i] = dst[31-8*i -: 8];
      pkt[24] = 8'h00;
      pkt[25] = 8'h00;
      sum = hdr_sum();
      c = 16'(32'hFFFF - (sum % 65535));
      if (!good) c = c ^ (16'h0001 << $urandom_range(0, 15));
      pkt[24] = c[15:8];
      pkt[25] = c[7:0];
   endtask

   task automatic load_words(input logic [159:0] h);
      for (int i = 0; i < 20; i++) pkt[14+i] = h[159-8*i -: 8];
   endtask

   function automatic ent_t model_entry(input bit runt, input bit psv, input bit cpu);
      ent_t e;
      int unsigned sum;
      sum    = hdr_sum();
      e.mac  = {pkt[0], pkt[1], pkt[2], pkt[3], pkt[4], pkt[5]};
      e.et   = {pkt[12], pkt[13]};
      e.ttl  = pkt[22];
      e.dst  = runt ? {pkt[30], pkt[31], 16'h0} : {pkt[30], pkt[31], pkt[32], pkt[33]};
      e.ok   = !runt && e.et == 16'h0800 && pkt[14] == 8'h45 &&
               (sum % 65535) == 0 && sum != 0 && pkt[22] != 8'h00;
      e.cpu  = psv & cpu;
      return e;
   endfunction

   task automatic drive_beat(input int b, input bit w1, input bit w2, input bit last,
                             input bit psv, input bit cpu, input bit rd);
      for (int n = 0; n < 32; n++) bus.i_tdata[8*n +: 8] = pkt[32*b + n];
      bus.i_tvalid          = 1'b1;
      bus.i_pkt_word1       = w1;
      bus.i_pkt_word2       = w2;
      bus.i_tlast           = last;
      bus.i_pktstate_valid  = psv;
      bus.i_pkt_is_from_cpu = cpu;
      bus.i_hdr_rd          = rd;
   endtask

   task automatic send_pkt(input int nbeats, input bit psv, input bit cpu,
                           input bit rd_commit, input int gap);
      bit   commit;
      ent_t e;
      for (int b = 0; b < nbeats; b++) begin
         commit = (b == 0 && nbeats == 1) || (b == 1);
         if (b == 1) begin
            for (int g = 0; g < gap; g++) begin
               idle_inputs();
               @(posedge clk);
               #1;
            end
         end
         drive_beat(b, b == 0, b == 1, b == nbeats - 1, psv, cpu, commit & rd_commit);
         @(negedge clk);
         chk("rd_pktstate", bus.o_rd_pktstate, commit & psv);
         if (commit) begin
            e = model_entry(nbeats == 1, psv, cpu);
            if (rd_commit && exp_q.size() > 0) void'(exp_q.pop_front());
            if (exp_q.size() < DEPTH) exp_q.push_back(e);
            else if (exp_drop < 65535) exp_drop++;
         end
         @(posedge clk);
         #1;
      end
      idle_inputs();
   endtask

   task automatic check_out(input string tag);
      chk({tag, ".valid"}, bus.o_hdr_valid, exp_q.size() > 0);
      chk({tag, ".nearly_full"}, bus.o_nearly_full, exp_q.size() >= DEPTH - 1);
      chk({tag, ".drop"}, bus.o_drop_count, exp_drop);
      if (exp_q.size() > 0) begin
         chk({tag, ".dst_mac"}, bus.o_dst_mac, exp_q[0].mac);
         chk({tag, ".ethertype"}, bus.o_ethertype, exp_q[0].et);
         chk({tag, ".ttl"}, bus.o_ttl, exp_q[0].ttl);
         chk({tag, ".ip_dst"}, bus.o_ip_dst, exp_q[0].dst);
         chk({tag, ".ip_ok"}, bus.o_ip_ok, exp_q[0].ok);
         chk({tag, ".from_cpu"}, bus.o_from_cpu, exp_q[0].cpu);
      end
   endtask

   task automatic pop();
      bus.i_hdr_rd = 1'b1;
      @(posedge clk);
      #1;
      bus.i_hdr_rd = 1'b0;
      if (exp_q.size() > 0) void'(exp_q.pop_front());
   endtask

   task automatic build_random();
      logic [47:0] m;
      logic [15:0] et;
      logic [7:0]  vihl, ttl;
      m    = {16'($urandom()), $urandom()};
      et   = ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'($urandom());
      vihl = ($urandom_range(0, 4) != 0) ? 8'h45 : 8'($urandom());
      ttl  = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom_range(1, 255));
      build(m, et, vihl, ttl, $urandom(), $urandom_range(0, 9) < 7);
   endtask

   localparam logic [159:0] HDR_GOOD = 160'h4500_0073_0000_4000_4011_b861_c0a8_0001_c0a8_00c7;
   localparam logic [159:0] HDR_BAD  = 160'h4500_0073_0000_4000_4011_b862_c0a8_0001_c0a8_00c7;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, want finish before 2ms");
      $fatal(1, "timeout");
   end

   initial begin
      int r, nb;
      idle_inputs();
      #12;
      chk("reset.valid", bus.o_hdr_valid, 1'b0);
      chk("reset.nearly_full", bus.o_nearly_full, 1'b0);
      chk("reset.drop", bus.o_drop_count, 16'h0);
      chk("reset.rd_pktstate", bus.o_rd_pktstate, 1'b0);
      chk("reset.dst_mac", bus.o_dst_mac, 48'h0);
      chk("reset.ip_dst", bus.o_ip_dst, 32'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      pop();
      check_out("empty_rd");

      // Reference IPv4 header with a correct checksum.
      build(48'h0011_2233_4455, 16'h0800, 8'h45, 8'h40, 32'h0, 1'b1);
      load_words(HDR_GOOD);
      send_pkt(2, 1'b1, 1'b0, 1'b0, 0);
      check_out("good");
      chk("good.ip_ok_const", bus.o_ip_ok, 1'b1);
      chk("good.ttl_const", bus.o_ttl, 8'h40);
      chk("good.ip_dst_const", bus.o_ip_dst, 32'hC0A800C7);
      repeat (3) @(posedge clk);
      #1;
      check_out("good_stable");
      pop();

      build(48'h0011_2233_4455, 16'h0800, 8'h45, 8'h40, 32'h0, 1'b1);
      load_words(HDR_BAD);
      send_pkt(2, 1'b1, 1'b0, 1'b0, 1);
      check_out("badsum");
      chk("badsum.ip_ok_const", bus.o_ip_ok, 1'b0);
      chk("badsum.ip_dst_const", bus.o_ip_dst, 32'hC0A800C7);
      pop();

      build(48'h3333_0000_0001, 16'h86DD, 8'h45, 8'h40, 32'h1234_5678, 1'b1);
      send_pkt(2, 1'b1, 1'b1, 1'b0, 0);
      check_out("ipv6");
      chk("ipv6.ip_ok_const", bus.o_ip_ok, 1'b0);
      chk("ipv6.from_cpu_const", bus.o_from_cpu, 1'b1);
      pop();

      build(48'h0200_0000_0001, 16'h0800, 8'h45, 8'h10, 32'h0A00_0001, 1'b1);
      send_pkt(2, 1'b0, 1'b1, 1'b0, 0);
      check_out("no_pktstate");
      pop();

      build(48'h0200_0000_0002, 16'h0800, 8'h45, 8'h20, 32'h0A00_0002, 1'b1);
      send_pkt(1, 1'b1, 1'b0, 1'b0, 0);
      check_out("runt");
      chk("runt.ip_ok_const", bus.o_ip_ok, 1'b0);
      build(48'h0200_0000_0003, 16'h0800, 8'h45, 8'h20, 32'h0A00_0003, 1'b1);
      send_pkt(2, 1'b1, 1'b0, 1'b0, 0);
      pop();
      check_out("after_runt");
      chk("after_runt.ip_ok_const", bus.o_ip_ok, 1'b1);
      pop();

      // Five back-to-back packets into a four-entry FIFO.
      for (int k = 0; k < 5; k++) begin
         build_random();
         send_pkt(2, 1'b1, k[0], 1'b0, 0);
         if (k == 2) chk("burst.nearly_full_after3", bus.o_nearly_full, 1'b1);
      end
      check_out("burst");
      chk("burst.drop_const", bus.o_drop_count, 16'd1);
      build_random();
      send_pkt(2, 1'b1, 1'b0, 1'b1, 0);
      check_out("full_wr_rd");

      // Reset between word1 and word2 discards the partial header and the FIFO.
      build_random();
      drive_beat(0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst.valid", bus.o_hdr_valid, 1'b0);
      chk("midrst.nearly_full", bus.o_nearly_full, 1'b0);
      chk("midrst.drop", bus.o_drop_count, 16'h0);
      chk("midrst.ttl", bus.o_ttl, 8'h0);
      idle_inputs();
      exp_q.delete();
      exp_drop = 0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      drive_beat(1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      chk("stray_w2.rd_pktstate", bus.o_rd_pktstate, 1'b0);
      @(posedge clk);
      #1;
      idle_inputs();
      check_out("stray_w2");
      build(48'h0200_0000_0004, 16'h0800, 8'h45, 8'h40, 32'hC0A8_0101, 1'b1);
      send_pkt(2, 1'b1, 1'b0, 1'b0, 0);
      check_out("post_rst");
      chk("post_rst.ip_ok_const", bus.o_ip_ok, 1'b1);
      pop();

      for (int p = 0; p < 80; p++) begin
         build_random();
         r  = $urandom_range(0, 9);
         nb = (r == 0) ? 1 : ((r < 7) ? 2 : 3);
         send_pkt(nb, $urandom_range(0, 7) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 4) == 0, $urandom_range(0, 2));
         check_out("rand");
         r = $urandom_range(0, 2);
         for (int q = 0; q < r; q++) begin
            pop();
            check_out("rand_pop");
         end
      end

      for (int q = 0; q < DEPTH + 1; q++) begin
         pop();
         check_out("drain");
      end

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule

// File: doc/hdr_extract.md
HDR_EXTRACT -- requirements
Module: hdr_extract

Interface
REQ-001 SHALL have parameter C_S_AXIS_DATA_WIDTH, default 256, stream data width; only 256 is supported.
REQ-002 SHALL have parameter C_S_AXIS_TUSER_WIDTH, default 128, stream sideband width; accepted but unused.
REQ-003 SHALL have parameter FIFO_DEPTH_BITS, default 2, log2 of result FIFO depth.
REQ-004 axi_aclk  in  1  sole clock; all logic on rising edge.
REQ-005 axi_resetn  in  1  asynchronous active-low reset.
REQ-006 i_tdata  in  256  stream data; byte n at bits [8n+7:8n]; multi-byte fields big-endian, lowest byte offset most significant.
REQ-007 i_tvalid  in  1  accepted beat qualifier.
REQ-008 i_tlast  in  1  last beat of packet.
REQ-009 i_pkt_word1  in  1  from pktstate; current beat is word1 (bytes 0-31).
REQ-010 i_pkt_word2  in  1  from pktstate; current beat is word2 (bytes 32-63).
REQ-011 i_pkt_is_from_cpu  in  1  pktstate FIFO head: packet came from a CPU port.
REQ-012 i_pktstate_valid  in  1  pktstate FIFO non-empty.
REQ-013 o_rd_pktstate  out  1  pop pktstate FIFO.
REQ-014 o_hdr_valid  out  1  result FIFO non-empty.
REQ-015 i_hdr_rd  in  1  pop result FIFO head.
REQ-016 o_dst_mac  out  48  bytes 0-5.
REQ-017 o_ethertype  out  16  bytes 12-13.
REQ-018 o_ttl  out  8  byte 22.
REQ-019 o_ip_dst  out  32  bytes 30-33.
REQ-020 o_ip_ok  out  1  IPv4 header acceptable for fast path.
REQ-021 o_from_cpu  out  1  captured i_pkt_is_from_cpu.
REQ-022 o_nearly_full  out  1  result FIFO holds >= depth-1 entries.
REQ-023 o_drop_count  out  16  entries lost to full FIFO.

Function
REQ-024 States SHALL be IDLE and HAVE_W1; IDLE -> HAVE_W1 on i_tvalid & i_pkt_word1 & !i_tlast; HAVE_W1 -> IDLE on i_tvalid & i_pkt_word2; remain in HAVE_W1 on beats without i_pkt_word2.
REQ-025 On word1 beat SHALL register dst_mac, ethertype, version/IHL (byte 14), ttl, ip_dst[31:16] (bytes 30-31), and partial checksum sum of 16-bit words at bytes 14..31 (9 words) into 20 bits.
REQ-026 On word2 beat SHALL add bytes 32-33, fold carries twice into 16 bits, and commit an entry the same edge; ip_dst[15:0] = bytes 32-33.
REQ-027 o_ip_ok SHALL be ethertype==0x0800 & version==4 & IHL==5 & folded sum==0xFFFF & ttl!=0.
REQ-028 Word1 beat with i_tlast (runt) SHALL commit immediately with o_ip_ok=0, ip_dst[15:0]=0, stay IDLE.
REQ-029 o_rd_pktstate SHALL pulse 1 cycle exactly on the commit cycle when i_pktstate_valid=1; if i_pktstate_valid=0 at commit, o_from_cpu=0 and no pop.
REQ-030 Result FIFO: fall-through, 2**FIFO_DEPTH_BITS entries; committed entry visible on outputs the cycle after the commit edge.
REQ-031 Commit while FIFO full SHALL discard the entry, still pop pktstate, and increment o_drop_count, saturating at 0xFFFF.
REQ-032 Simultaneous commit and i_hdr_rd on full FIFO SHALL accept the entry (no drop).
REQ-033 i_hdr_rd while empty SHALL be ignored.
REQ-034 Output fields SHALL be stable while o_hdr_valid=1 and no i_hdr_rd.

Reset
REQ-035 Assertion of axi_resetn=0 SHALL immediately force state IDLE, FIFO empty, o_hdr_valid=0, o_rd_pktstate=0, o_nearly_full=0, o_drop_count=0, all field outputs 0.
REQ-036 Reset mid-packet SHALL discard the partial header; first word1 after deassertion starts a fresh capture.

Verification
REQ-037 Header 4500 0073 0000 4000 4011 b861 c0a8 0001 c0a8 00c7, ethertype 0x0800, from_cpu=0 -> one entry: o_ip_ok=1, o_ttl=0x40, o_ip_dst=0xC0A800C7, one o_rd_pktstate pulse.
REQ-038 Same header with checksum b862 -> o_ip_ok=0, other fields identical.
REQ-039 Ethertype 0x86DD, 64-byte frame, from_cpu=1 -> o_ip_ok=0, o_from_cpu=1.
REQ-040 Five back-to-back packets, i_hdr_rd held 0 -> four entries, o_nearly_full=1 after third, o_drop_count=1.
REQ-041 32-byte runt (tlast on word1) -> entry with o_ip_ok=0, state stays IDLE, next packet parsed correctly.
REQ-042 axi_resetn pulsed low between word1 and word2 -> no entry, o_drop_count=0, next packet yields correct entry.
